// File: rtl/barrel_shifter_pipe.sv
// Pipelined multifunction barrel shifter: rotate/shift by amt over AW registered
// log2 stages, with a single global advance for valid/ready backpressure.
module barrel_shifter_pipe #(
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [AW-1:0] amt,
   input  logic [2:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // The whole pipe moves together when adv = !out_valid || out_ready;
   // in_ready is that same adv, and bubbles advance like data.

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_LSL = 3'b010;
   localparam logic [2:0] OP_LSR = 3'b011;
   localparam logic [2:0] OP_ASR = 3'b100;

   logic [W-1:0]  data_q [AW];
   logic [W-1:0]  data_d [AW];
   logic [2:0]    op_q   [AW];
   logic [2:0]    op_d   [AW];
   logic [AW-1:0] amt_q  [AW];
   logic [AW-1:0] amt_d  [AW];
   logic [AW-1:0] sign_q, sign_d;
   logic [AW-1:0] valid_q, valid_d;
   logic          adv;

   function automatic logic [W-1:0] shift_stage(input logic [W-1:0] d,
                                                input logic [2:0]   o,
                                                input logic         s,
                                                input int unsigned  sh);
      logic [W-1:0] fill;
      fill = s ? ~({W{1'b1}} >> sh) : '0;
      case (o)
         OP_ROL:  shift_stage = (d << sh) | (d >> (W - sh));
         OP_ROR:  shift_stage = (d >> sh) | (d << (W - sh));
         OP_LSL:  shift_stage = d << sh;
         OP_LSR:  shift_stage = d >> sh;
         OP_ASR:  shift_stage = (d >> sh) | fill;
         default: shift_stage = d;
      endcase
   endfunction

   for (genvar k = 0; k < AW; k++) begin : g_stage
      logic [W-1:0]  src_data;
      logic [2:0]    src_op;
      logic [AW-1:0] src_amt;
      logic          src_sign;
      logic          src_valid;

      if (k == 0) begin : g_first
         // The sign is frozen here so later stages fill with the original MSB.
         assign src_data  = a;
         assign src_op    = op;
         assign src_amt   = amt;
         assign src_sign  = a[W-1];
         assign src_valid = in_valid;
      end else begin : g_rest
         assign src_data  = data_q[k-1];
         assign src_op    = op_q[k-1];
         assign src_amt   = amt_q[k-1];
         assign src_sign  = sign_q[k-1];
         assign src_valid = valid_q[k-1];
      end

      assign data_d[k]  = src_amt[k] ? shift_stage(src_data, src_op, src_sign, 1 << k)
                                     : src_data;
      assign op_d[k]    = src_op;
      assign amt_d[k]   = src_amt;
      assign sign_d[k]  = src_sign;
      assign valid_d[k] = src_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < AW; k++) begin
            data_q[k] <= '0;
            op_q[k]   <= '0;
            amt_q[k]  <= '0;
         end
         sign_q  <= '0;
         valid_q <= '0;
      end else if (adv) begin
         for (int k = 0; k < AW; k++) begin
            data_q[k] <= data_d[k];
            op_q[k]   <= op_d[k];
            amt_q[k]  <= amt_d[k];
         end
         sign_q  <= sign_d;
         valid_q <= valid_d;
      end
   end

   assign adv       = !valid_q[AW-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = valid_q[AW-1];
   assign y         = data_q[AW-1];

   // Last-stage side fields have no consumer downstream.
   logic unused_tail;
   assign unused_tail = ^{op_q[AW-1], amt_q[AW-1], sign_q[AW-1]};

endmodule
